// File: rtl/ex_muldiv.sv
// Iterative multiply/divide unit owning the HI/LO pair: shift-add multiply and
// restoring divide over WIDTH cycles, followed by one sign-correction cycle.
module ex_muldiv #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             mthi,
    input  logic             mtlo,
    input  logic [WIDTH-1:0] wdata,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIX
    } state_t;

    state_t           state;
    logic [CW-1:0]    count;
    logic             is_div;
    logic             neg_q;
    logic             neg_r;
    logic             b_zero;
    logic             ovf;
    logic [WIDTH-1:0] a_raw;
    logic [WIDTH-1:0] opnd;
    logic [WIDTH-1:0] work_hi;
    logic [WIDTH-1:0] work_lo;

    // Operand magnitudes and sign bookkeeping, taken from the live inputs at start.
    logic             sign_a;
    logic             sign_b;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;

    always_comb begin
        sign_a = ~op[0] & op_a[WIDTH-1];
        sign_b = ~op[0] & op_b[WIDTH-1];
        mag_a  = sign_a ? -op_a : op_a;
        mag_b  = sign_b ? -op_b : op_b;
    end

    // One iteration step. Multiply keeps {work_hi, work_lo} as the partial
    // product with the multiplier shifting out of work_lo; divide keeps the
    // partial remainder in work_hi and shifts quotient bits into work_lo.
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH:0]   div_diff;
    logic [WIDTH-1:0] next_hi;
    logic [WIDTH-1:0] next_lo;

    always_comb begin
        mul_sum   = {1'b0, work_hi} + (work_lo[0] ? {1'b0, opnd} : '0);
        div_shift = {work_hi, work_lo[WIDTH-1]};
        div_diff  = div_shift - {1'b0, opnd};
        next_hi   = work_hi;
        next_lo   = work_lo;
        if (!is_div) begin
            next_hi = mul_sum[WIDTH:1];
            next_lo = {mul_sum[0], work_lo[WIDTH-1:1]};
        end else if (!div_diff[WIDTH]) begin
            next_hi = div_diff[WIDTH-1:0];
            next_lo = {work_lo[WIDTH-2:0], 1'b1};
        end else begin
            next_hi = div_shift[WIDTH-1:0];
            next_lo = {work_lo[WIDTH-2:0], 1'b0};
        end
    end

    // Sign correction and the architectural special cases, committed in FIX.
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   fix_hi;
    logic [WIDTH-1:0]   fix_lo;

    always_comb begin
        prod   = {work_hi, work_lo};
        fix_hi = '0;
        fix_lo = '0;
        if (!is_div) begin
            if (neg_q) begin
                prod = -prod;
            end
            fix_hi = prod[2*WIDTH-1:WIDTH];
            fix_lo = prod[WIDTH-1:0];
        end else if (b_zero) begin
            fix_hi = a_raw;
            fix_lo = '1;
        end else if (ovf) begin
            fix_hi = '0;
            fix_lo = {1'b1, {(WIDTH-1){1'b0}}};
        end else begin
            fix_hi = neg_r ? -work_hi : work_hi;
            fix_lo = neg_q ? -work_lo : work_lo;
        end
    end

    // Control FSM; HI/LO only change on MTHI/MTLO in IDLE or at the FIX commit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            count   <= '0;
            is_div  <= 1'b0;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
            b_zero  <= 1'b0;
            ovf     <= 1'b0;
            a_raw   <= '0;
            opnd    <= '0;
            work_hi <= '0;
            work_lo <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            hi      <= '0;
            lo      <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && !flush) begin
                        state   <= RUN;
                        busy    <= 1'b1;
                        count   <= '0;
                        is_div  <= op[1];
                        neg_q   <= sign_a ^ sign_b;
                        neg_r   <= sign_a;
                        b_zero  <= (op_b == '0);
                        ovf     <= ~op[0] & (op_a == {1'b1, {(WIDTH-1){1'b0}}}) & (op_b == '1);
                        a_raw   <= op_a;
                        opnd    <= op[1] ? mag_b : mag_a;
                        work_hi <= '0;
                        work_lo <= op[1] ? mag_a : mag_b;
                    end else if (!start) begin
                        if (mthi) begin
                            hi <= wdata;
                        end
                        if (mtlo) begin
                            lo <= wdata;
                        end
                    end
                end
                RUN: begin
                    if (flush) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        work_hi <= next_hi;
                        work_lo <= next_lo;
                        count   <= count + 1'b1;
                        if (count == LAST) begin
                            state <= FIX;
                        end
                    end
                end
                FIX: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    if (!flush) begin
                        hi   <= fix_hi;
                        lo   <= fix_lo;
                        done <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ex_muldiv.sv
// Self-checking bench for ex_muldiv: directed corner cases plus random ops
// compared against a plain-arithmetic HI/LO reference model.
module tb_ex_muldiv;

    localparam int W = 32;

    logic         clk;
    logic         rst;
    logic         start;
    logic [1:0]   op;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         mthi;
    logic         mtlo;
    logic [W-1:0] wdata;
    logic         flush;
    logic         busy;
    logic         done;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    int checks   = 0;
    int failures = 0;

    ex_muldiv #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .op    (op),
        .op_a  (op_a),
        .op_b  (op_b),
        .mthi  (mthi),
        .mtlo  (mtlo),
        .wdata (wdata),
        .flush (flush),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Returns {HI, LO} straight from the architectural definition of each op.
    function automatic logic [63:0] ref_model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        longint     sp;
        logic [63:0] up;
        int         sa;
        int         sb;
        int         q;
        int         r;
        sa = a;
        sb = b;
        case (o)
            2'b00: begin
                sp = longint'(sa) * longint'(sb);
                return sp;
            end
            2'b01: begin
                up = {32'h0, a} * {32'h0, b};
                return up;
            end
            2'b10: begin
                if (b == 32'h0) return {a, 32'hFFFF_FFFF};
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
                q = sa / sb;
                r = sa % sb;
                return {r, q};
            end
            default: begin
                if (b == 32'h0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
        endcase
    endfunction

    // Presents start for one edge; returns at the falling edge of cycle E0+1.
    task automatic apply_stimulus(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        start = 1'b1;
        op    = o;
        op_a  = a;
        op_b  = b;
        @(negedge clk);
        start = 1'b0;
        op    = 2'($urandom_range(0, 3));
        op_a  = $urandom;
        op_b  = $urandom;
    endtask

    // Follows the op from cycle E0+1 to its done pulse; optionally pokes
    // start+mthi during one busy cycle, which must have no effect.
    task automatic wait_result(input string tag, input logic [63:0] expected, input int poke);
        int          busy_n;
        bit          stable;
        int          i;
        logic [31:0] h0;
        logic [31:0] l0;
        busy_n = 0;
        stable = 1'b1;
        h0     = hi;
        l0     = lo;
        for (i = 0; i < 60 && !done; i++) begin
            if (busy) busy_n++;
            if (hi !== h0 || lo !== l0) stable = 1'b0;
            if (i == poke) begin
                start = 1'b1;
                op    = 2'b01;
                op_a  = $urandom;
                op_b  = $urandom;
                mthi  = 1'b1;
                wdata = 32'h1234;
            end else begin
                start = 1'b0;
                mthi  = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        mthi  = 1'b0;
        check_output({tag, " latency"}, 64'(i), 64'(W + 1));
        check_output({tag, " busy_cycles"}, 64'(busy_n), 64'(W + 1));
        check_output({tag, " hilo_stable"}, 64'(stable), 64'd1);
        check_output({tag, " done"}, 64'(done), 64'd1);
        check_output({tag, " busy_at_done"}, 64'(busy), 64'd0);
        check_output({tag, " hilo"}, {hi, lo}, expected);
        @(negedge clk);
        check_output({tag, " done_pulse"}, 64'(done), 64'd0);
    endtask

    task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, input int poke);
        logic [63:0] expected;
        expected = ref_model(o, a, b);
        apply_stimulus(o, a, b);
        wait_result(tag, expected, poke);
    endtask

    task automatic preload(input logic [31:0] h, input logic [31:0] l);
        @(negedge clk);
        mthi  = 1'b1;
        wdata = h;
        @(negedge clk);
        mthi  = 1'b0;
        mtlo  = 1'b1;
        wdata = l;
        @(negedge clk);
        mtlo  = 1'b0;
    endtask

    initial begin
        logic [1:0]  ro;
        logic [31:0] ra;
        logic [31:0] rb;
        int          done_n;

        rst   = 1'b1;
        start = 1'b0;
        op    = 2'b00;
        op_a  = '0;
        op_b  = '0;
        mthi  = 1'b0;
        mtlo  = 1'b0;
        wdata = '0;
        flush = 1'b0;
        repeat (2) @(negedge clk);
        check_output("reset busy", 64'(busy), 64'd0);
        check_output("reset done", 64'(done), 64'd0);
        check_output("reset hilo", {hi, lo}, 64'd0);
        rst = 1'b0;

        run_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1);
        check_output("multu_max const", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
        run_op("mult_neg3x5", 2'b00, 32'hFFFF_FFFD, 32'd5, -1);
        run_op("mult_min_sq", 2'b00, 32'h8000_0000, 32'h8000_0000, -1);
        run_op("div_m7_2", 2'b10, 32'hFFFF_FFF9, 32'd2, -1);
        run_op("divu_7_2", 2'b11, 32'd7, 32'd2, -1);
        run_op("div_7_m2", 2'b10, 32'd7, 32'hFFFF_FFFE, -1);
        run_op("divu_by0", 2'b11, 32'd5, 32'd0, -1);
        run_op("div_neg_by0", 2'b10, 32'hFFFF_FFF0, 32'd0, -1);
        run_op("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, -1);

        // start and mthi during a run are ignored
        run_op("busy_poke", 2'b00, 32'd1234567, 32'hFFFF_FF00, 4);
        ra = hi;
        @(negedge clk);
        mtlo  = 1'b1;
        wdata = 32'hABCD;
        @(negedge clk);
        mtlo  = 1'b0;
        check_output("mtlo lo", 64'(lo), 64'h ABCD);
        check_output("mtlo hi_kept", 64'(hi), 64'(ra));

        @(negedge clk);
        mthi  = 1'b1;
        mtlo  = 1'b1;
        wdata = 32'h5555_AAAA;
        @(negedge clk);
        mthi  = 1'b0;
        mtlo  = 1'b0;
        check_output("mthi_mtlo both", {hi, lo}, 64'h5555_AAAA_5555_AAAA);

        // start together with mthi: start wins, HI stays until commit
        @(negedge clk);
        start = 1'b1;
        op    = 2'b11;
        op_a  = 32'd100;
        op_b  = 32'd7;
        mthi  = 1'b1;
        wdata = 32'h999;
        @(negedge clk);
        start = 1'b0;
        mthi  = 1'b0;
        check_output("start_wins busy", 64'(busy), 64'd1);
        check_output("start_wins hi", 64'(hi), 64'h5555_AAAA);
        wait_result("start_wins", ref_model(2'b11, 32'd100, 32'd7), -1);

        // flush in the 10th busy cycle
        preload(32'h11, 32'h22);
        apply_stimulus(2'b00, 32'h7654_3210, 32'h0000_0123);
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check_output("flush busy", 64'(busy), 64'd0);
        check_output("flush hilo", {hi, lo}, 64'h0000_0011_0000_0022);
        done_n = 0;
        repeat (40) begin
            if (done) done_n++;
            @(negedge clk);
        end
        check_output("flush no_done", 64'(done_n), 64'd0);
        check_output("flush hilo_later", {hi, lo}, 64'h0000_0011_0000_0022);

        // flush with start in IDLE: nothing starts
        @(negedge clk);
        start = 1'b1;
        flush = 1'b1;
        op    = 2'b01;
        @(negedge clk);
        start = 1'b0;
        flush = 1'b0;
        check_output("flush_start busy", 64'(busy), 64'd0);

        // asynchronous reset mid-operation
        apply_stimulus(2'b00, 32'h0000_0011, 32'h0000_0022);
        repeat (9) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_output("async_rst busy", 64'(busy), 64'd0);
        check_output("async_rst hilo", {hi, lo}, 64'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int n = 0; n < 24; n++) begin
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 5))
                0: rb = 32'h0;
                1: rb = 32'($urandom_range(1, 9));
                2: ra = 32'h8000_0000;
                3: rb = 32'hFFFF_FFFF;
                default: ;
            endcase
            run_op($sformatf("rand%0d op%0d", n, ro), ro, ra, rb, -1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ex_muldiv.md
Name: ex_muldiv

Overview:
Iterative multiply/divide unit in the EX stage that owns the HI/LO register pair. It executes MULT, MULTU, DIV and DIVU over multiple cycles, and handles MTHI/MTLO writes. It drives hi/lo toward the EX result path, which feeds the ALU_data input of the write-back select mux. Its busy output goes to the hazard unit, which stalls IF/ID/EX while an operation is in flight.

Parameters:
WIDTH, 32, operand width; HI and LO are each WIDTH bits; RUN phase lasts WIDTH cycles.

Ports:
clk  input  1  clock, rising-edge.
rst  input  1  asynchronous, active-high reset.
start  input  1  request to begin op with op_a/op_b; only honoured in IDLE.
op  input  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
op_a  input  WIDTH  multiplicand / dividend (rs).
op_b  input  WIDTH  multiplier / divisor (rt).
mthi  input  1  write wdata to HI.
mtlo  input  1  write wdata to LO.
wdata  input  WIDTH  data for MTHI/MTLO.
flush  input  1  abort the in-flight operation (pipeline flush).
busy  output  1  high while state is RUN or FIX.
done  output  1  one-cycle pulse; HI/LO hold the new result.
hi  output  WIDTH  HI register.
lo  output  WIDTH  LO register.

Behaviour:
- Reset (async, any time including mid-operation):
  - state=IDLE; hi=0, lo=0, busy=0, done=0.
  - Iteration counter and working registers cleared.
- States: IDLE, RUN, FIX.
  - IDLE -> RUN on start at a clock edge. op, op_a and op_b are captured there; the inputs are don't-care afterwards.
  - RUN lasts exactly WIDTH cycles: one shift-add (multiply) or one restoring subtract-shift (divide) per cycle, on operand magnitudes for signed ops.
  - RUN -> FIX when the counter reaches WIDTH-1.
  - FIX is one cycle: sign correction. At the FIX->IDLE edge, HI/LO are written and done is set.
- Timing: start sampled at edge E0.
  - busy=1 in cycles E0+1 .. E0+WIDTH+1 (WIDTH+1 cycles).
  - hi/lo show the new result and done=1 in cycle E0+WIDTH+2.
  - done lasts one cycle.
  - For WIDTH=32 this is 33 busy cycles.
- busy is registered, derived from state only, with no combinational path from start.
  - The hazard unit is responsible for stalling a dependent instruction in the cycle start is issued.
- Multiply: 2*WIDTH-bit product; HI=upper half, LO=lower half.
  - MULT is two's complement; MULTU is unsigned.
- Divide: truncation toward zero; LO=quotient, HI=remainder.
  - Signed quotient is negative iff operand signs differ.
  - Signed remainder takes the sign of the dividend.
- Divisor zero (DIV or DIVU): full latency still applies; LO=all ones, HI=op_a as captured.
- Signed overflow, most-negative / -1: LO=most-negative value, HI=0.
- start while busy: ignored; no restart, no queueing.
- mthi/mtlo in IDLE without start: the selected register(s) load wdata at the next edge.
  - Both asserted writes both registers.
- mthi/mtlo with start in the same IDLE cycle: start wins; the writes are dropped.
- mthi/mtlo while busy: ignored.
- done cycle: state is IDLE, so start or mthi/mtlo in that cycle are honoured normally.
- flush while busy: return to IDLE at the next edge.
  - HI/LO are left unchanged and no done pulse is produced.
  - flush in IDLE has no effect; flush together with start in IDLE: flush wins, no operation starts.
- hi/lo always show the committed registers. Intermediate values never appear on them.

Test Plan:
- MULTU 0xFFFFFFFF*0xFFFFFFFF, start at E0 -> busy high 33 cycles; in cycle E0+34 done=1, hi=0xFFFFFFFE, lo=0x00000001.
- MULT -3*5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1. MULT 0x80000000*0x80000000 -> hi=0x40000000, lo=0.
- DIV -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 7/2 -> lo=3, hi=1. DIV 7/-2 -> lo=0xFFFFFFFD, hi=1.
- DIVU 5/0 -> lo=0xFFFFFFFF, hi=5 after full latency. DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- During a run, pulse start with new operands and mthi with wdata=0x1234 -> both ignored; result matches the original op. Then mtlo with wdata=0xABCD in IDLE -> lo=0xABCD at the next edge, hi unchanged.
- Preload hi/lo=0x11/0x22, start MULT, then either:
  - assert flush in the 10th busy cycle -> busy=0 next cycle, hi/lo remain 0x11/0x22, no done.
  - repeat and assert rst instead -> busy=0, hi=lo=0 immediately, with no clock edge required.
